// File: rtl/rect_fill.sv
// rect_fill: fills an axis-aligned rectangle of a packed 8-bit-per-pixel
// framebuffer with a single palette index. Four pixels share one 32-bit word.
// The rectangle is clipped to the screen, then written one word per cycle,
// row by row, with per-byte lane enables for partial edge words.
//
// Ports:
//   clk, reset         clock; asynchronous active-high reset
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_x, cmd_y       top-left pixel of the rectangle
//   cmd_w, cmd_h       rectangle size in pixels (zero means nothing to draw)
//   cmd_color          palette index replicated into every written byte
//   busy               high from acceptance until the block is idle again
//   done               one-cycle completion pulse
//   fb_wr_addr/data/en framebuffer word write port (en is per byte lane)
module rect_fill #(
   parameter int RESOLUTION_X = 400,
   parameter int RESOLUTION_Y = 300,
   parameter int PIXEL_BITS   = 8
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic                                           cmd_valid,
   output logic                                           cmd_ready,
   input  logic [$clog2(RESOLUTION_X)-1:0]                cmd_x,
   input  logic [$clog2(RESOLUTION_Y)-1:0]                cmd_y,
   input  logic [$clog2(RESOLUTION_X):0]                  cmd_w,
   input  logic [$clog2(RESOLUTION_Y):0]                  cmd_h,
   input  logic [PIXEL_BITS-1:0]                          cmd_color,
   output logic                                           busy,
   output logic                                           done,
   output logic [$clog2(RESOLUTION_X*RESOLUTION_Y/4)-1:0] fb_wr_addr,
   output logic [31:0]                                    fb_wr_data,
   output logic [3:0]                                     fb_wr_en
);

   localparam int XW = $clog2(RESOLUTION_X);
   localparam int YW = $clog2(RESOLUTION_Y);
   localparam int AW = $clog2(RESOLUTION_X * RESOLUTION_Y / 4);
   localparam int CW = XW - 2;   // word-column index width
   localparam int XS = XW + 2;   // wide enough for x + w without overflow
   localparam int YS = YW + 2;

   localparam logic [XS-1:0] RX_S = XS'(RESOLUTION_X);
   localparam logic [YS-1:0] RY_S = YS'(RESOLUTION_Y);
   localparam logic [AW-1:0] WPR  = AW'(RESOLUTION_X / 4);   // words per row

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [XW-1:0]         x0_q, x0_d;
   logic [YW-1:0]         y0_q, y0_d;
   logic [XW:0]           w_q, w_d;
   logic [YW:0]           h_q, h_d;
   logic [PIXEL_BITS-1:0] color_q, color_d;
   logic [XS-1:0]         x1_q, x1_d;
   logic [CW-1:0]         col_q, col_d;
   logic [CW-1:0]         last_col_q, last_col_d;
   logic [YW-1:0]         row_q, row_d;
   logic [YW-1:0]         last_row_q, last_row_d;
   logic [AW-1:0]         row_base_q, row_base_d;
   logic [AW-1:0]         fb_wr_addr_q, fb_wr_addr_d;
   logic [31:0]           fb_wr_data_q, fb_wr_data_d;
   logic [3:0]            fb_wr_en_q, fb_wr_en_d;
   logic [3:0]            lane_en;
   logic                  wr_next;

   // Clipping of the captured command, evaluated while in SETUP.
   logic [XS-1:0] x_sum, x1_clip;
   logic [YS-1:0] y_sum, y1_clip;
   logic [CW-1:0] last_col_c;
   logic [YW-1:0] last_row_c;
   logic          empty;

   assign x_sum      = {2'b00, x0_q} + {1'b0, w_q};
   assign y_sum      = {2'b00, y0_q} + {1'b0, h_q};
   assign x1_clip    = (x_sum > RX_S) ? RX_S : x_sum;
   assign y1_clip    = (y_sum > RY_S) ? RY_S : y_sum;
   assign last_col_c = CW'((x1_clip - XS'(1)) >> 2);
   assign last_row_c = YW'(y1_clip - YS'(1));
   assign empty      = (w_q == '0) || (h_q == '0) ||
                       ({2'b00, x0_q} >= RX_S) || ({2'b00, y0_q} >= RY_S);

   always_comb begin
      state_d      = state_q;
      x0_d         = x0_q;
      y0_d         = y0_q;
      w_d          = w_q;
      h_d          = h_q;
      color_d      = color_q;
      x1_d         = x1_q;
      col_d        = col_q;
      last_col_d   = last_col_q;
      row_d        = row_q;
      last_row_d   = last_row_q;
      row_base_d   = row_base_q;
      fb_wr_data_d = fb_wr_data_q;
      wr_next      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               x0_d    = cmd_x;
               y0_d    = cmd_y;
               w_d     = cmd_w;
               h_d     = cmd_h;
               color_d = cmd_color;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (empty) begin
               state_d = S_DONE;
            end else begin
               // Preload the first word so it is on the port in the first WRITE cycle.
               state_d      = S_WRITE;
               x1_d         = x1_clip;
               last_col_d   = last_col_c;
               last_row_d   = last_row_c;
               row_d        = y0_q;
               col_d        = CW'(x0_q >> 2);
               row_base_d   = AW'(y0_q) * WPR;
               fb_wr_data_d = 32'({4{color_q}});
               wr_next      = 1'b1;
            end
         end
         S_WRITE: begin
            // The port currently shows (row_q, col_q); select the word after it.
            if (col_q == last_col_q) begin
               if (row_q == last_row_q) begin
                  state_d = S_DONE;
               end else begin
                  row_d      = row_q + YW'(1);
                  col_d      = CW'(x0_q >> 2);
                  row_base_d = row_base_q + WPR;
                  wr_next    = 1'b1;
               end
            end else begin
               col_d   = col_q + CW'(1);
               wr_next = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Lane k of the selected word holds pixel 4*col+k; enable it only inside [x0, x1).
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [XS-1:0] px;
         assign px          = {2'b00, col_d, 2'(gi)};
         assign lane_en[gi] = (px >= {2'b00, x0_q}) && (px < x1_d);
      end
   endgenerate

   assign fb_wr_en_d   = wr_next ? lane_en : 4'b0000;
   assign fb_wr_addr_d = wr_next ? (row_base_d + AW'(col_d)) : fb_wr_addr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         x0_q         <= '0;
         y0_q         <= '0;
         w_q          <= '0;
         h_q          <= '0;
         color_q      <= '0;
         x1_q         <= '0;
         col_q        <= '0;
         last_col_q   <= '0;
         row_q        <= '0;
         last_row_q   <= '0;
         row_base_q   <= '0;
         fb_wr_addr_q <= '0;
         fb_wr_data_q <= '0;
         fb_wr_en_q   <= '0;
      end else begin
         state_q      <= state_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         w_q          <= w_d;
         h_q          <= h_d;
         color_q      <= color_d;
         x1_q         <= x1_d;
         col_q        <= col_d;
         last_col_q   <= last_col_d;
         row_q        <= row_d;
         last_row_q   <= last_row_d;
         row_base_q   <= row_base_d;
         fb_wr_addr_q <= fb_wr_addr_d;
         fb_wr_data_q <= fb_wr_data_d;
         fb_wr_en_q   <= fb_wr_en_d;
      end
   end

   // Ready is masked by reset so it stays low for the whole reset pulse.
   assign cmd_ready  = (state_q == S_IDLE) && !reset;
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign fb_wr_addr = fb_wr_addr_q;
   assign fb_wr_data = fb_wr_data_q;
   assign fb_wr_en   = fb_wr_en_q;

endmodule

// File: doc/rect_fill.md
RECT_FILL -- requirements
Module: rect_fill

Interface
REQ-001 Parameter RESOLUTION_X, default 400, framebuffer width in pixels; SHALL be a multiple of 4.
REQ-002 Parameter RESOLUTION_Y, default 300, framebuffer height in pixels.
REQ-003 Parameter PIXEL_BITS, default 8, palette index width; the block SHALL support only 8.
REQ-004 clk  input  1  single clock; all logic in this domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmd_valid  input  1  fill command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_x  input  $clog2(RESOLUTION_X)  left pixel column.
REQ-009 cmd_y  input  $clog2(RESOLUTION_Y)  top pixel row.
REQ-010 cmd_w  input  $clog2(RESOLUTION_X)+1  width in pixels.
REQ-011 cmd_h  input  $clog2(RESOLUTION_Y)+1  height in pixels.
REQ-012 cmd_color  input  PIXEL_BITS  palette index to fill.
REQ-013 busy  output  1  command in progress (any state other than IDLE).
REQ-014 done  output  1  one-cycle pulse at command completion.
REQ-015 fb_wr_addr  output  $clog2(RESOLUTION_X*RESOLUTION_Y/4)  framebuffer word address.
REQ-016 fb_wr_data  output  32  four packed pixels.
REQ-017 fb_wr_en  output  4  per-byte write enables; fb_wr_en[k] qualifies fb_wr_data[8k+7:8k].

Function
REQ-018 States IDLE, SETUP, WRITE, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-019 A command SHALL be accepted on the rising edge where cmd_valid and cmd_ready are both 1; cmd_* SHALL be captured on that edge and may change afterwards.
REQ-020 IDLE -> SETUP on acceptance; SETUP lasts exactly one cycle.
REQ-021 SETUP clipping: x1 = min(cmd_x+cmd_w, RESOLUTION_X) and y1 = min(cmd_y+cmd_h, RESOLUTION_Y), computed without overflow.
REQ-022 SETUP empty check: if cmd_w==0, cmd_h==0, cmd_x>=RESOLUTION_X or cmd_y>=RESOLUTION_Y, the next state SHALL be DONE with no writes; otherwise the next state SHALL be WRITE.
REQ-023 Pixel (x,y) SHALL map to word address y*(RESOLUTION_X/4)+(x>>2), byte lane x[1:0].
REQ-024 WRITE SHALL issue exactly one registered word write per cycle, covering rows cmd_y..y1-1 top to bottom and, within each row, words (cmd_x>>2)..((x1-1)>>2) in ascending address order, with no idle cycles between rows.
REQ-025 fb_wr_data SHALL equal {4{color}} on every write.
REQ-026 Each written word SHALL enable exactly the lanes whose pixel x lies in [cmd_x, x1-1]; this covers a partial first word, a partial last word, and a single word that is partial on both sides.
REQ-027 fb_wr_en SHALL be 4'b0000 whenever no write is issued; fb_wr_addr and fb_wr_data are don't-care then.
REQ-028 WRITE -> DONE in the cycle after the last write; DONE asserts done for one cycle, then -> IDLE.
REQ-029 Latency: for acceptance at edge T, the first write SHALL appear in cycle T+2; done SHALL assert in the cycle after the last write (T+2 for an empty command).
REQ-030 A cmd_valid held during busy SHALL NOT be accepted until the block returns to IDLE; back-to-back commands SHALL incur one IDLE cycle.
REQ-031 The block SHALL NOT apply backpressure to the framebuffer, and the framebuffer write port SHALL always accept writes.

Reset
REQ-032 While reset is 1, the state SHALL be IDLE and cmd_ready=0, busy=0, done=0, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, asynchronously.
REQ-033 cmd_ready SHALL rise in the first cycle after reset deasserts.
REQ-034 Reset asserted mid-command SHALL abort the command immediately: no further writes and no done pulse.

Verification
REQ-035 x=0,y=0,w=4,h=1,color=0xAB -> one write at T+2: addr 0, data 0xABABABAB, en 1111; done at T+3.
REQ-036 x=5,y=2,w=6,h=1 -> writes at addr 201 (en 1110) then addr 202 (en 0111); done one cycle later.
REQ-037 x=398,y=299,w=10,h=10 -> clipped to one write at addr 29999, en 1100; done follows.
REQ-038 w=0 (any other fields) -> no write enables asserted; done at T+2; cmd_ready back to 1 at T+3.
REQ-039 x=0,y=0,w=8,h=4 with reset pulsed during row 2 -> fb_wr_en=0 from reset assertion, no done, cmd_ready=1 the cycle after release.
REQ-040 cmd_valid held high through two commands -> the second is accepted only after the first done, and the write sequence contains no overlap.
